// File: rtl/mpc_input_ctrl.sv
// mpc_input_ctrl -- ingress controller for one write port of the multi-port cache.
//
// Parses the packet header word and passes DA, priority and the head block
// address to the queue manager. Prefetches free block addresses from the
// allocator into a small FIFO, and issues one SRAM write address per
// received word. Every word, header included, uses one block address.
//
// Optional feature: define MPC_IC_LEN_CHECK_EN to add o_len_err. It flags a
// word count that disagrees with the header length, or a packet that had a
// word arrive while the address FIFO was empty.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_blk_addr_vld/i_blk_addr   free-address grant from the allocator
//   i_sop, i_eop       1-cycle packet start / end pulses
//   i_wr_vld/i_wr_data input words; the first word after i_sop is the header
//   o_sop, o_hdr_vld, o_blk_addr_vld   1-cycle header pulses
//   o_da, o_prority, o_blk_addr        header fields, held until next header
//   o_eop              packet end pulse to the queue manager
//   o_sram_addr_vld/o_sram_addr        per-word SRAM write address
//   o_addr_req         level request to the allocator, one request per high cycle
//   o_len_err          (MPC_IC_LEN_CHECK_EN only) length error, pulses with o_eop

module mpc_input_ctrl #(
    parameter int ADDR_FIFO_DEPTH = 4,
    parameter int BLK_ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int DA_WIDTH        = 4,
    parameter int PRORITY_WIDTH   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_blk_addr_vld,
    input  logic [BLK_ADDR_WIDTH-1:0] i_blk_addr,
    input  logic                      i_sop,
    input  logic                      i_wr_vld,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_eop,
    output logic                      o_sop,
    output logic [DA_WIDTH-1:0]       o_da,
    output logic [PRORITY_WIDTH-1:0]  o_prority,
    output logic                      o_hdr_vld,
    output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
    output logic                      o_blk_addr_vld,
    output logic                      o_eop,
    output logic [BLK_ADDR_WIDTH-1:0] o_sram_addr,
    output logic                      o_sram_addr_vld,
    output logic                      o_addr_req
`ifdef MPC_IC_LEN_CHECK_EN
    , output logic                    o_len_err
`endif
);

    localparam int PTR_W   = $clog2(ADDR_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PRI_LSB = DA_WIDTH;
    localparam int LEN_LSB = DA_WIDTH + PRORITY_WIDTH;
    localparam int LEN_W   = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]                state;
    logic [BLK_ADDR_WIDTH-1:0] fifo_mem [ADDR_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          fifo_cnt;
    logic [CNT_W-1:0]          fifo_cnt_nxt;
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W-1:0]          outstanding_nxt;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      word_in;
    logic                      push;
    logic                      pop;

    assign word_in    = i_wr_vld && (state == ST_HDR || state == ST_DATA);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(ADDR_FIFO_DEPTH));
    assign push       = i_blk_addr_vld && !fifo_full;
    assign pop        = word_in && !fifo_empty;

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop)
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        else if (pop && !push)
            fifo_cnt_nxt = fifo_cnt - 1'b1;
    end

    // Requests in flight: a request cycle adds one, a grant removes one.
    always_comb begin
        outstanding_nxt = outstanding;
        if (o_addr_req && !i_blk_addr_vld && outstanding != '1)
            outstanding_nxt = outstanding + 1'b1;
        else if (!o_addr_req && i_blk_addr_vld && outstanding != '0)
            outstanding_nxt = outstanding - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= i_blk_addr;
    end

    // The request is evaluated on next-cycle occupancy so that the number of
    // granted plus in-flight addresses never exceeds the FIFO depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            o_addr_req  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt    <= fifo_cnt_nxt;
            outstanding <= outstanding_nxt;
            o_addr_req  <= ({1'b0, fifo_cnt_nxt} + {1'b0, outstanding_nxt})
                           < (CNT_W+1)'(ADDR_FIFO_DEPTH);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            o_sop           <= 1'b0;
            o_hdr_vld       <= 1'b0;
            o_blk_addr_vld  <= 1'b0;
            o_eop           <= 1'b0;
            o_da            <= '0;
            o_prority       <= '0;
            o_blk_addr      <= '0;
            o_sram_addr     <= '0;
            o_sram_addr_vld <= 1'b0;
        end else begin
            o_sop           <= 1'b0;
            o_hdr_vld       <= 1'b0;
            o_blk_addr_vld  <= 1'b0;
            o_eop           <= 1'b0;
            o_sram_addr_vld <= pop;
            if (pop)
                o_sram_addr <= fifo_mem[rd_ptr];
            case (state)
                ST_IDLE: begin
                    if (i_sop)
                        state <= ST_HDR;
                end
                ST_HDR: begin
                    if (i_wr_vld) begin
                        state          <= ST_DATA;
                        o_sop          <= 1'b1;
                        o_hdr_vld      <= 1'b1;
                        o_blk_addr_vld <= 1'b1;
                        o_da           <= i_wr_data[DA_WIDTH-1:0];
                        o_prority      <= i_wr_data[PRI_LSB +: PRORITY_WIDTH];
                        o_blk_addr     <= fifo_mem[rd_ptr];
                    end
                end
                ST_DATA: begin
                    if (i_eop) begin
                        state <= ST_IDLE;
                        o_eop <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MPC_IC_LEN_CHECK_EN
    logic [LEN_W-1:0] hdr_len;
    logic [LEN_W-1:0] word_cnt;
    logic             empty_seen;
    logic [LEN_W:0]   exp_words;
    logic             unused_data;

    assign exp_words   = ({1'b0, hdr_len} + (LEN_W+1)'(3)) >> 2;
    assign unused_data = ^i_wr_data[DATA_WIDTH-1:LEN_LSB+LEN_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hdr_len    <= '0;
            word_cnt   <= '0;
            empty_seen <= 1'b0;
            o_len_err  <= 1'b0;
        end else begin
            o_len_err <= 1'b0;
            if (state == ST_HDR && i_wr_vld) begin
                hdr_len    <= i_wr_data[LEN_LSB +: LEN_W];
                word_cnt   <= LEN_W'(1);
                empty_seen <= fifo_empty;
            end else if (state == ST_DATA) begin
                if (i_wr_vld) begin
                    if (word_cnt != '1)
                        word_cnt <= word_cnt + 1'b1;
                    if (fifo_empty)
                        empty_seen <= 1'b1;
                end
                if (i_eop)
                    o_len_err <= ({1'b0, word_cnt} != exp_words) || empty_seen;
            end
        end
    end
`else
    logic unused_data;
    assign unused_data = ^i_wr_data[DATA_WIDTH-1:LEN_LSB];
`endif

endmodule

// File: tb/tb_mpc_input_ctrl.sv
// tb_mpc_input_ctrl -- self-checking bench for mpc_input_ctrl.
// A behavioural model of the port predicts SRAM addresses, header events and
// packet-end events into queues; a negedge monitor pops and compares them
// against the DUT outputs. An allocator model answers each request cycle with
// a sequential address one cycle later, and can be stalled.

module tb_mpc_input_ctrl;

    localparam int BLK = 10;

    typedef struct packed {
        logic [3:0]     da;
        logic [2:0]     pri;
        logic [BLK-1:0] blk;
    } hdr_t;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_blk_addr_vld;
    logic [BLK-1:0] i_blk_addr;
    logic           i_sop;
    logic           i_wr_vld;
    logic [31:0]    i_wr_data;
    logic           i_eop;
    logic           o_sop;
    logic [3:0]     o_da;
    logic [2:0]     o_prority;
    logic           o_hdr_vld;
    logic [BLK-1:0] o_blk_addr;
    logic           o_blk_addr_vld;
    logic           o_eop;
    logic [BLK-1:0] o_sram_addr;
    logic           o_sram_addr_vld;
    logic           o_addr_req;
`ifdef MPC_IC_LEN_CHECK_EN
    logic           o_len_err;
`endif

    mpc_input_ctrl #(.ADDR_FIFO_DEPTH(4), .BLK_ADDR_WIDTH(BLK)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_blk_addr_vld  (i_blk_addr_vld),
        .i_blk_addr      (i_blk_addr),
        .i_sop           (i_sop),
        .i_wr_vld        (i_wr_vld),
        .i_wr_data       (i_wr_data),
        .i_eop           (i_eop),
        .o_sop           (o_sop),
        .o_da            (o_da),
        .o_prority       (o_prority),
        .o_hdr_vld       (o_hdr_vld),
        .o_blk_addr      (o_blk_addr),
        .o_blk_addr_vld  (o_blk_addr_vld),
        .o_eop           (o_eop),
        .o_sram_addr     (o_sram_addr),
        .o_sram_addr_vld (o_sram_addr_vld),
        .o_addr_req      (o_addr_req)
`ifdef MPC_IC_LEN_CHECK_EN
        , .o_len_err     (o_len_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input int len, input int pri, input int da);
        logic [9:0] l;
        logic [2:0] p;
        logic [3:0] d;
        l = len[9:0];
        p = pri[2:0];
        d = da[3:0];
        return {15'd0, l, p, d};
    endfunction

    // Scoreboard queues
    int   sram_q[$];
    hdr_t hdr_q[$];
    bit   eop_q[$];

    // Allocator model
    int pend      = 0;
    int next_addr = 0;
    bit stall     = 0;

    initial begin
        i_blk_addr_vld = 1'b0;
        i_blk_addr     = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n === 1'b1 && o_addr_req === 1'b1)
                pend++;
            @(posedge i_clk);
            #1;
            if (!stall && pend > 0) begin
                i_blk_addr_vld = 1'b1;
                i_blk_addr     = next_addr[BLK-1:0];
                next_addr++;
                pend--;
            end else begin
                i_blk_addr_vld = 1'b0;
                i_blk_addr     = '0;
            end
        end
    end

    // Behavioural model of the port
    int m_state = 0;        // 0 idle, 1 header expected, 2 payload
    int m_fifo[$];
    int m_words = 0;
    int m_len   = 0;
    bit m_emp   = 0;
    int mdl_empty = 0;

    initial begin
        forever begin
            @(posedge i_clk);
            if (i_rst_n !== 1'b1) begin
                m_state = 0;
                m_fifo.delete();
                sram_q.delete();
                hdr_q.delete();
                eop_q.delete();
            end else begin
                bit   full;
                bit   hit;
                int   a;
                hdr_t h;
                full = (m_fifo.size() >= 4);
                a    = 0;
                if ((m_state == 1 || m_state == 2) && i_wr_vld) begin
                    hit = (m_fifo.size() > 0);
                    if (hit) begin
                        a = m_fifo.pop_front();
                        sram_q.push_back(a);
                    end else begin
                        mdl_empty++;
                        m_emp = 1;
                    end
                    if (m_state == 1) begin
                        h.da    = i_wr_data[3:0];
                        h.pri   = i_wr_data[6:4];
                        h.blk   = a[BLK-1:0];
                        hdr_q.push_back(h);
                        m_words = 1;
                        m_len   = int'(i_wr_data[16:7]);
                        m_emp   = !hit;
                        m_state = 2;
                    end else begin
                        m_words++;
                    end
                end else if (m_state == 2 && i_eop) begin
                    eop_q.push_back((m_words != (m_len + 3) / 4) || m_emp);
                    m_state = 0;
                end else if (m_state == 0 && i_sop) begin
                    m_state = 1;
                end
                if (i_blk_addr_vld && !full)
                    m_fifo.push_back(int'(i_blk_addr));
            end
        end
    end

    // Output monitor
    int sram_seen = 0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst_n === 1'b1) begin
                int   a;
                hdr_t h;
                bit   e;
                if (o_sram_addr_vld) begin
                    sram_seen++;
                    if (sram_q.size() == 0) begin
                        check_val("sram_unexpected", 1, 0);
                    end else begin
                        a = sram_q.pop_front();
                        check_val("sram_addr", 32'(o_sram_addr), a);
                    end
                end else if (sram_q.size() != 0) begin
                    a = sram_q.pop_front();
                    check_val("sram_missing", 0, 1);
                end

                if (o_sop) begin
                    if (hdr_q.size() == 0) begin
                        check_val("sop_unexpected", 1, 0);
                    end else begin
                        h = hdr_q.pop_front();
                        check_val("hdr_strobes", {o_hdr_vld, o_blk_addr_vld}, 2'b11);
                        check_val("hdr_da", 32'(o_da), 32'(h.da));
                        check_val("hdr_pri", 32'(o_prority), 32'(h.pri));
                        check_val("hdr_blk", 32'(o_blk_addr), 32'(h.blk));
                    end
                end else if (o_hdr_vld || o_blk_addr_vld) begin
                    check_val("hdr_strobe_no_sop", {o_hdr_vld, o_blk_addr_vld}, 2'b00);
                end else if (hdr_q.size() != 0) begin
                    h = hdr_q.pop_front();
                    check_val("sop_missing", 0, 1);
                end

                if (o_eop) begin
                    if (eop_q.size() == 0) begin
                        check_val("eop_unexpected", 1, 0);
                    end else begin
                        e = eop_q.pop_front();
`ifdef MPC_IC_LEN_CHECK_EN
                        check_val("len_err", 32'(o_len_err), 32'(e));
`endif
                    end
                end else begin
`ifdef MPC_IC_LEN_CHECK_EN
                    if (o_len_err)
                        check_val("len_err_no_eop", 1, 0);
`endif
                    if (eop_q.size() != 0) begin
                        e = eop_q.pop_front();
                        check_val("eop_missing", 0, 1);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int nwords);
        i_sop = 1'b1;
        tick();
        i_sop = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            i_wr_vld  = 1'b1;
            i_wr_data = (i == 0) ? hdr : $urandom;
            tick();
        end
        i_wr_vld = 1'b0;
        i_eop    = 1'b1;
        tick();
        i_eop    = 1'b0;
    endtask

    initial begin
        int e0;
        int s0;
        i_rst_n   = 1'b0;
        i_sop     = 1'b0;
        i_wr_vld  = 1'b0;
        i_wr_data = '0;
        i_eop     = 1'b0;

        repeat (2) @(posedge i_clk);
        #1;
        check_val("rst_pulses", {o_sop, o_hdr_vld, o_blk_addr_vld, o_eop, o_sram_addr_vld, o_addr_req}, 6'b0);
        check_val("rst_fields", {o_da, o_prority}, 7'b0);
        check_val("rst_addrs", {o_blk_addr, o_sram_addr}, 20'b0);
`ifdef MPC_IC_LEN_CHECK_EN
        check_val("rst_len_err", 32'(o_len_err), 0);
`endif
        i_rst_n = 1'b1;
        tick();
        check_val("req_after_rst", 32'(o_addr_req), 1);
        repeat (6) tick();
        check_val("fifo_prefill", m_fifo.size(), 4);

        // Stray word with no start of packet: must not consume an address.
        i_wr_vld  = 1'b1;
        i_wr_data = mk_hdr(8, 2, 3);
        tick();
        i_wr_vld  = 1'b0;
        repeat (2) tick();

        // Long packet, one word per cycle, with a stray i_sop mid-payload.
        e0 = mdl_empty;
        s0 = sram_seen;
        i_sop = 1'b1;
        tick();
        i_sop = 1'b0;
        for (int i = 0; i < 256; i++) begin
            i_wr_vld  = 1'b1;
            i_wr_data = (i == 0) ? mk_hdr(1022, 1, 4) : $urandom;
            i_sop     = (i == 100);
            tick();
        end
        i_wr_vld = 1'b0;
        i_sop    = 1'b0;
        i_eop    = 1'b1;
        tick();
        i_eop    = 1'b0;
        repeat (2) tick();
        check_val("burst_no_gap", mdl_empty - e0, 0);
        check_val("burst_writes", sram_seen - s0, 256);
        check_val("burst_next_addr", next_addr, 260);
        repeat (4) tick();

        // Allocator stalled: short packet, then a packet that drains the FIFO.
        stall = 1;
        s0 = sram_seen;
        send_pkt(mk_hdr(16, 5, 9), 3);
        send_pkt(mk_hdr(12, 7, 15), 3);
        tick();
        check_val("req_drop", 32'(o_addr_req), 0);
        check_val("outstanding", pend, 4);
        check_val("empty_no_write", sram_seen - s0, 4);
        stall = 0;
        repeat (6) tick();
        check_val("fifo_refill", m_fifo.size(), 4);

        // Popping the header address re-opens a request slot.
        i_sop = 1'b1;
        tick();
        i_sop     = 1'b0;
        i_wr_vld  = 1'b1;
        i_wr_data = mk_hdr(8, 0, 1);
        tick();
        check_val("req_reassert", 32'(o_addr_req), 1);
        i_wr_data = 32'hdead_beef;
        tick();
        i_wr_vld = 1'b0;
        i_eop    = 1'b1;
        tick();
        i_eop    = 1'b0;
        repeat (4) tick();
        check_val("sb_drain", sram_q.size() + hdr_q.size() + eop_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
